// File: rtl/onchip_mem_arb_pkg.sv
// Shared definitions for the two-port on-chip RAM arbiter.
// Holds the default geometry of the RAM (word address width, data width,
// byteenable width, number of implemented words), the port identifier type
// and the request record that the arbiter muxes onto the RAM port.
package onchip_mem_arb_pkg;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int BE_W      = DATA_W / 8;
    localparam int NUM_WORDS = 32036;

    // Identifies one of the two slave ports (0 or 1).
    typedef logic port_id_t;

    // One slave-port access as presented to the RAM.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic              write;
        logic [DATA_W-1:0] writedata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// Ports:
//   request[1:0]  in   request from port 0 / port 1
//   last          in   port that received the most recent grant
//   grant[1:0]    out  one-hot (or zero) grant
// A lone requester always wins; with both requesting, the port that was
// not granted last wins. The `last` state is held by the caller.
module rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  logic [1:0] request,
    input  port_id_t   last,
    output logic [1:0] grant
);

    always_comb begin
        grant[0] = request[0] & (~request[1] | last);
        grant[1] = request[1] & (~request[0] | ~last);
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port, byte-enabled on-chip RAM (one-cycle read latency,
// unregistered output) between two Avalon-MM masters.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   sN_address/byteenable/read/write/writedata   slave port N request
//   sN_waitrequest                slave port N stall
//   sN_readdata/readdatavalid     slave port N read response
//   mem_address/byteenable/chipselect/write/writedata/clken   RAM controls
//   mem_readdata                  RAM read data (one cycle after the address)
//
// Handshake: a port requests with read or write high and must hold its
// request until it sees waitrequest low in the same cycle; that cycle is the
// acceptance. Write wins over read when both are high. A read response
// appears exactly one cycle after acceptance as a one-cycle readdatavalid
// pulse on the port that issued it; there is no backpressure on responses.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W    = onchip_mem_arb_pkg::DATA_W,
    parameter int BE_W      = onchip_mem_arb_pkg::BE_W,
    parameter int NUM_WORDS = onchip_mem_arb_pkg::NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    import onchip_mem_arb_pkg::*;

    logic [1:0]  req;
    logic [1:0]  grant;
    mem_req_t    req0;
    mem_req_t    req1;
    mem_req_t    sel_req;
    port_id_t    sel;
    logic        any_grant;
    logic        sel_oor;
    logic        rd_accept;
    logic        rd_valid;
    logic [DATA_W-1:0] rd_data;

    port_id_t    last_q, last_d;
    logic        rd_pend_q, rd_pend_d;
    port_id_t    rd_port_q, rd_port_d;
    logic        rd_oor_q, rd_oor_d;

    // Requests are masked in reset so nothing is granted and both ports stall.
    assign req = {s1_read | s1_write, s0_read | s0_write} & {2{reset_n}};

    rr_arb2 u_rr_arb2 (
        .request (req),
        .last    (last_q),
        .grant   (grant)
    );

    always_comb begin
        req0      = '{address: s0_address, byteenable: s0_byteenable,
                      write: s0_write, writedata: s0_writedata};
        req1      = '{address: s1_address, byteenable: s1_byteenable,
                      write: s1_write, writedata: s1_writedata};
        sel       = grant[1];
        any_grant = |grant;
        sel_req   = sel ? req1 : req0;
        sel_oor   = int'(sel_req.address) >= NUM_WORDS;
        // A granted access that is not a write is a read.
        rd_accept = any_grant & ~sel_req.write;

        last_d    = any_grant ? sel : last_q;
        rd_pend_d = rd_accept;
        rd_port_d = rd_accept ? sel : rd_port_q;
        rd_oor_d  = rd_accept ? sel_oor : rd_oor_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
            rd_oor_q  <= rd_oor_d;
        end
    end

    // Idle ports see waitrequest low; only a losing requester is stalled.
    assign s0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
    assign s1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

    assign mem_address    = sel_req.address;
    assign mem_byteenable = sel_req.byteenable;
    assign mem_writedata  = sel_req.writedata;
    assign mem_chipselect = any_grant;
    // Out-of-range writes are accepted but never reach the RAM.
    assign mem_write      = any_grant & sel_req.write & ~sel_oor;
    assign mem_clken      = reset_n;

    // Gating with reset_n drops a response whose read was accepted just
    // before reset asserted.
    assign rd_valid = rd_pend_q & reset_n;
    assign rd_data  = rd_oor_q ? '0 : mem_readdata;

    assign s0_readdatavalid = rd_valid & (rd_port_q == 1'b0);
    assign s1_readdatavalid = rd_valid & (rd_port_q == 1'b1);
    assign s0_readdata      = s0_readdatavalid ? rd_data : '0;
    assign s1_readdata      = s1_readdatavalid ? rd_data : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [14:0] s0_address, s1_address;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_writedata, s1_writedata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_address       (s0_address),
    .s0_byteenable    (s0_byteenable),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_byteenable    (s1_byteenable),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // ---------------- RAM model ----------------
  // Registered address, unregistered data. Addresses past the implemented
  // range return a junk pattern so a missing zero-substitution shows up.
  logic [31:0] ram [0:32767];
  logic [14:0] ram_rd_q = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32768; i++) ram[i] <= '0;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_rd_q <= mem_address;
    end
  end

  assign mem_readdata = (int'(ram_rd_q) >= 32036) ? 32'hBAD0_BAD0 : ram[ram_rd_q];

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] rw0, input logic [14:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic [1:0] rw1, input logic [14:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    s0_read = rw0[1]; s0_write = rw0[0]; s0_address = a0; s0_byteenable = be0; s0_writedata = d0;
    s1_read = rw1[1]; s1_write = rw1[0]; s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
  endtask

  task automatic idle();
    drive(2'b00, 15'h0, 4'h0, 32'h0, 2'b00, 15'h0, 4'h0, 32'h0);
  endtask

  // ---------------- vector table ----------------
  // rw = {read, write}; ewcs = {wait0, wait1, chipselect, write}; ev = {valid0, valid1}
  typedef struct {
    logic [1:0]  rw0;  logic [14:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic [1:0]  rw1;  logic [14:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic [3:0]  ewcs; logic [14:0] eaddr;
    logic [1:0]  ev;   logic [31:0] erd0; logic [31:0] erd1;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rw0, input logic [14:0] a0, input logic [3:0] be0,
                              input logic [31:0] d0, input logic [1:0] rw1, input logic [14:0] a1,
                              input logic [3:0] be1, input logic [31:0] d1, input logic [3:0] ewcs,
                              input logic [14:0] eaddr, input logic [1:0] ev,
                              input logic [31:0] erd0, input logic [31:0] erd1);
    vec_t v;
    v.rw0 = rw0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
    v.rw1 = rw1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
    v.ewcs = ewcs; v.eaddr = eaddr; v.ev = ev; v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  function automatic logic [31:0] exp_data(input logic [14:0] a);
    case (a)
      15'h10:  return 32'hDEADBEAA;
      15'h20:  return 32'h11112222;
      15'h05:  return 32'h00000055;
      default: return 32'h0;
    endcase
  endfunction

  vec_t tbl[16];

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {port, data}

  initial begin
    logic [14:0] a0l[4];
    logic [14:0] a1l[4];
    logic [32:0] e;
    logic        exp_last;
    logic        win;
    int          i0, i1, cnt0, cnt1;

    // Test after reset; `last` in the DUT ends at 0 after row 15.
    tbl[0]  = mk(2'b01, 15'h10,   4'hF, 32'hDEADBEEF, 2'b00, 15'h0,    4'h0, 32'h0,        4'b0011, 15'h10,   2'b00, 32'h0,        32'h0);
    tbl[1]  = mk(2'b10, 15'h10,   4'hF, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0010, 15'h10,   2'b00, 32'h0,        32'h0);
    tbl[2]  = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0000, 15'h0,    2'b10, 32'hDEADBEEF, 32'h0);
    tbl[3]  = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b01, 15'h10,   4'h1, 32'h000000AA, 4'b0011, 15'h10,   2'b00, 32'h0,        32'h0);
    tbl[4]  = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b10, 15'h10,   4'hF, 32'h0,        4'b0010, 15'h10,   2'b00, 32'h0,        32'h0);
    tbl[5]  = mk(2'b10, 15'h10,   4'hF, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0010, 15'h10,   2'b01, 32'h0,        32'hDEADBEAA);
    tbl[6]  = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0000, 15'h0,    2'b10, 32'hDEADBEAA, 32'h0);
    tbl[7]  = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b10, 15'h7D24, 4'hF, 32'h0,        4'b0010, 15'h7D24, 2'b00, 32'h0,        32'h0);
    tbl[8]  = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b01, 15'h7D28, 4'hF, 32'h12345678, 4'b0010, 15'h7D28, 2'b01, 32'h0,        32'h0);
    tbl[9]  = mk(2'b11, 15'h5,    4'hF, 32'h00000055, 2'b00, 15'h0,    4'h0, 32'h0,        4'b0011, 15'h5,    2'b00, 32'h0,        32'h0);
    tbl[10] = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0000, 15'h0,    2'b00, 32'h0,        32'h0);
    tbl[11] = mk(2'b01, 15'h20,   4'hF, 32'h11112222, 2'b10, 15'h10,   4'hF, 32'h0,        4'b1010, 15'h10,   2'b00, 32'h0,        32'h0);
    tbl[12] = mk(2'b01, 15'h20,   4'hF, 32'h11112222, 2'b00, 15'h0,    4'h0, 32'h0,        4'b0011, 15'h20,   2'b01, 32'h0,        32'hDEADBEAA);
    tbl[13] = mk(2'b10, 15'h5,    4'hF, 32'h0,        2'b10, 15'h20,   4'hF, 32'h0,        4'b1010, 15'h20,   2'b00, 32'h0,        32'h0);
    tbl[14] = mk(2'b10, 15'h5,    4'hF, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0010, 15'h5,    2'b01, 32'h0,        32'h11112222);
    tbl[15] = mk(2'b00, 15'h0,    4'h0, 32'h0,        2'b00, 15'h0,    4'h0, 32'h0,        4'b0000, 15'h0,    2'b10, 32'h00000055, 32'h0);

    a0l[0] = 15'h10; a0l[1] = 15'h20; a0l[2] = 15'h05; a0l[3] = 15'h10;
    a1l[0] = 15'h20; a1l[1] = 15'h05; a1l[2] = 15'h10; a1l[3] = 15'h20;

    // ---- reset with both ports requesting ----
    reset_n = 1'b0;
    drive(2'b10, 15'h10, 4'hF, 32'h0, 2'b10, 15'h11, 4'hF, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      chk1("rst wait0", s0_waitrequest, 1'b1);
      chk1("rst wait1", s1_waitrequest, 1'b1);
      chk1("rst cs", mem_chipselect, 1'b0);
      chk1("rst we", mem_write, 1'b0);
      chk1("rst clken", mem_clken, 1'b0);
      chk1("rst valid0", s0_readdatavalid, 1'b0);
      chk1("rst valid1", s1_readdatavalid, 1'b0);
      chk32("rst rdata0", s0_readdata, 32'h0);
      chk32("rst rdata1", s1_readdata, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk1("first grant wait0", s0_waitrequest, 1'b0);
    chk1("first grant wait1", s1_waitrequest, 1'b1);
    chk1("first grant cs", mem_chipselect, 1'b1);
    chk32("first grant addr", 32'(mem_address), 32'h10);
    chk1("clken after reset", mem_clken, 1'b1);
    @(negedge clk);
    idle();
    #2;
    chk1("first read valid0", s0_readdatavalid, 1'b1);
    chk32("first read data0", s0_readdata, 32'h0);
    chk1("first read valid1", s1_readdatavalid, 1'b0);

    // ---- vector table ----
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].rw0, tbl[i].a0, tbl[i].be0, tbl[i].d0, tbl[i].rw1, tbl[i].a1, tbl[i].be1, tbl[i].d1);
      #2;
      chk1($sformatf("row%0d wait0", i), s0_waitrequest, tbl[i].ewcs[3]);
      chk1($sformatf("row%0d wait1", i), s1_waitrequest, tbl[i].ewcs[2]);
      chk1($sformatf("row%0d cs", i), mem_chipselect, tbl[i].ewcs[1]);
      chk1($sformatf("row%0d we", i), mem_write, tbl[i].ewcs[0]);
      if (tbl[i].ewcs[1]) chk32($sformatf("row%0d addr", i), 32'(mem_address), 32'(tbl[i].eaddr));
      chk1($sformatf("row%0d valid0", i), s0_readdatavalid, tbl[i].ev[1]);
      chk1($sformatf("row%0d valid1", i), s1_readdatavalid, tbl[i].ev[0]);
      chk32($sformatf("row%0d rdata0", i), s0_readdata, tbl[i].erd0);
      chk32($sformatf("row%0d rdata1", i), s1_readdata, tbl[i].erd1);
    end
    chk32("ram[5] after rd+wr", ram[15'h5], 32'h00000055);
    chk32("ram[32040] untouched", ram[15'h7D28], 32'h0);
    chk32("ram[0x10] merged", ram[15'h10], 32'hDEADBEAA);

    // ---- both ports reading continuously ----
    exp_last = 1'b0;
    i0 = 0; i1 = 0; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 8) drive(2'b10, a0l[i0], 4'hF, 32'h0, 2'b10, a1l[i1], 4'hF, 32'h0);
      else idle();
      #2;
      if (s0_readdatavalid) cnt0++;
      if (s1_readdatavalid) cnt1++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk1($sformatf("rr c%0d valid0", c), s0_readdatavalid, ~e[32]);
        chk1($sformatf("rr c%0d valid1", c), s1_readdatavalid, e[32]);
        chk32($sformatf("rr c%0d rdata", c), e[32] ? s1_readdata : s0_readdata, e[31:0]);
      end else begin
        chk1($sformatf("rr c%0d idle valid0", c), s0_readdatavalid, 1'b0);
        chk1($sformatf("rr c%0d idle valid1", c), s1_readdatavalid, 1'b0);
      end
      if (c < 8) begin
        win = ~exp_last;
        chk1($sformatf("rr c%0d wait0", c), s0_waitrequest, win);
        chk1($sformatf("rr c%0d wait1", c), s1_waitrequest, ~win);
        chk1($sformatf("rr c%0d cs", c), mem_chipselect, 1'b1);
        chk32($sformatf("rr c%0d addr", c), 32'(mem_address), 32'(win ? a1l[i1] : a0l[i0]));
        exp_q.push_back({win, exp_data(win ? a1l[i1] : a0l[i0])});
        if (win) i1++; else i0++;
        exp_last = win;
      end
    end
    chk32("rr pulses port0", 32'(cnt0), 32'd4);
    chk32("rr pulses port1", 32'(cnt1), 32'd4);
    chk32("rr queue drained", 32'(exp_q.size()), 32'd0);

    // ---- reset right after an accepted read ----
    @(negedge clk);
    drive(2'b10, 15'h20, 4'hF, 32'h0, 2'b00, 15'h0, 4'h0, 32'h0);
    #2;
    chk1("midrst accept wait0", s0_waitrequest, 1'b0);
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    #2;
    chk1("midrst valid0 in reset", s0_readdatavalid, 1'b0);
    chk32("midrst rdata0 in reset", s0_readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk1("midrst valid0 after", s0_readdatavalid, 1'b0);
    chk1("midrst valid1 after", s1_readdatavalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port arbiter sharing the single-port 32036 x 32-bit on-chip RAM (byte-enabled, one-cycle read latency, unregistered output) between two Avalon-MM masters, e.g. the CPU data master and a DMA engine. It grants at most one access per cycle with round-robin fairness. It drives the RAM's address, byteenable, chipselect, write, writedata and clken. It returns read data with a tagged readdatavalid to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 15, word address width of RAM and of both slave ports
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- NUM_WORDS, 32036, number of implemented RAM words; higher addresses are out of range

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- sN_address  in  ADDR_W  port N word address (N = 0, 1 for every sN_ port)
- sN_byteenable  in  BE_W  port N byte lanes
- sN_read  in  1  port N read request
- sN_write  in  1  port N write request
- sN_writedata  in  DATA_W  port N write data
- sN_waitrequest  out  1  port N stall; request is accepted in the cycle this is low
- sN_readdata  out  DATA_W  port N read data
- sN_readdatavalid  out  1  port N read data valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  to RAM clock enable
- mem_readdata  in  DATA_W  from RAM, valid one cycle after an accepted read address

## Operation
- Request on port N: sN_read | sN_write. If both are high, the access is a write and the read is ignored.
- Grant is combinational in the request cycle.
  - With a single requester, that port is granted.
  - With two requesters, the port not granted last wins; the `last` register resets to 1, so port 0 wins first.
  - `last` updates only on a grant.
- The granted port has sN_waitrequest low. The other port has it high whenever it is requesting, and also low when idle.
- mem_* outputs mux the granted port.
  - mem_chipselect is high on any grant.
  - mem_write is high on a granted write with an in-range address.
- Out-of-range address (>= NUM_WORDS):
  - A write is accepted but suppressed (mem_write low).
  - A read is accepted and returns 0 with readdatavalid.
- Read tracking: registers rd_pend, rd_port and rd_oor capture any accepted read.
  - The next cycle, s[rd_port]_readdatavalid = 1 and readdata = rd_oor ? 0 : mem_readdata.
  - The non-target port's readdatavalid is 0 and its readdata is 0.
- mem_clken = reset_n (high outside reset).
- Fairness: a continuously requesting port waits at most 1 cycle.
- Back-to-back reads from either or both ports sustain one access per cycle. readdatavalid outputs are in order, one cycle after each acceptance.

## Timing
- Reset values: `last` = 1, rd_pend = 0, rd_port = 0, rd_oor = 0.
  - Both readdatavalid = 0 and both readdata = 0.
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0.
  - Both waitrequest = 1 while reset_n is low.
- Write latency is 0: accepted and committed at the same clock edge.
- Read latency is 1: data arrives in the cycle after acceptance.
- A read accepted in cycle k, followed by reset_n low in cycle k+1, produces no readdatavalid. rd_pend clears at the k+1 edge, and the output is gated by reset_n low.
- A write and a read from different ports in the same cycle: one is granted per round-robin, the other stalls one cycle.
- A same-address write in cycle k then read in cycle k+1 returns the new data.

## Structure
- Package onchip_mem_arb_pkg holds:
  - ADDR_W, DATA_W, BE_W, NUM_WORDS
  - typedef port_id_t (1-bit)
  - typedef mem_req_t {address, byteenable, write, writedata}
- Sub-module rr_arb2 (request[1:0], last, grant[1:0]) is combinational. The `last` register lives in onchip_mem_arbiter.

## Test plan
- Reset: hold reset_n low 3 cycles with both ports requesting -> both waitrequest = 1, mem_chipselect = 0, no readdatavalid; after release, port 0 is granted first.
- Write then read: s0 writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010 -> s0_readdatavalid = 1 one cycle later with 0xDEADBEEF. Then s1 writes 0x000000AA with byteenable 0x1 to the same address -> a later read returns 0xDEADBEAA.
- Contention: both ports read continuously for 8 cycles -> grants alternate 0,1,0,1…, each port gets 4 readdatavalid pulses, and no gap cycles occur.
- Out of range: s1 reads 32036 -> readdatavalid = 1 with data 0. s1 writes 0x12345678 to 32040 -> mem_write stays 0 and RAM contents are unchanged.
- Reset mid-read: s0 read accepted, then reset_n low the next cycle -> s0_readdatavalid never rises.
- Both read and write asserted on s0 at 0x0005 with data 0x55 -> a write occurs and no readdatavalid follows.
